// File: rtl/apb4_sram_pkg.sv
// apb4_sram_pkg -- shared types and default parameter values for the APB4 SRAM slave.
//   state_e        : transfer FSM states (IDLE, WAIT, RESP)
//   *_DEF          : default values for the apb4_sram parameters
//   CNT_W          : width of the wait-state counter (WAIT_STATES range 0..15)
package apb4_sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned DATA_WIDTH_DEF  = 32;
  localparam int unsigned ADDR_WIDTH_DEF  = 32;
  localparam int unsigned DEPTH_DEF       = 32;
  localparam int unsigned WAIT_STATES_DEF = 0;
  localparam int unsigned WAIT_STATES_MAX = 15;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/apb4_sram_mem.sv
// apb4_sram_mem -- byte-enabled word storage, no reset (contents undefined until written).
//   clk   : write clock
//   we    : write enable; lanes with strb[i]=1 are updated on the rising edge
//   strb  : byte-lane enables
//   index : word index (read and write)
//   wdata : write data
//   rdata : asynchronous read of the addressed word
module apb4_sram_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned IDX_W      = 5
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] strb,
  input  logic [IDX_W-1:0]        index,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (strb[i]) begin
          mem_q[index][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[index];

endmodule

// File: rtl/apb4_sram.sv
// apb4_sram -- APB4 slave fronting a DEPTH x DATA_WIDTH byte-enabled SRAM with a
// fixed number of wait states.
//   pclk, presetn        : clock, asynchronous active-low reset
//   psel, penable        : APB select / access-phase marker
//   pwrite               : 1 = write, 0 = read
//   paddr                : byte address
//   pwdata, pstrb        : write data and byte-lane enables
//   prdata               : registered read data (cleared on error reads)
//   pready               : registered transfer-complete, high in the last access cycle only
//   pslverr              : registered error (out of range or misaligned), valid with pready
module apb4_sram
  import apb4_sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned WAIT_STATES = WAIT_STATES_DEF
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH-1:0]   prdata_q;
  logic                    pready_q;
  logic                    pslverr_q;

  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [ADDR_WIDTH-1:0]   off_mask;
  logic                    addr_err;
  logic                    commit_d;
  logic                    mem_we_d;
  logic [DATA_WIDTH-1:0]   rdata_d;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  // Address decode: word index and error classification
  always_comb begin
    word_idx = paddr >> OFF_W;
    off_mask = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);
    addr_err = (word_idx >= ADDR_WIDTH'(DEPTH)) || ((paddr & off_mask) != '0);
  end

  // commit_d marks the edge that enters RESP; the access executes on that edge only.
  always_comb begin
    commit_d = 1'b0;
    unique case (state_q)
      IDLE:    commit_d = psel && !penable && (WAIT_STATES == 0);
      WAIT:    commit_d = psel && (cnt_q == CNT_W'(1));
      default: commit_d = 1'b0;
    endcase
    mem_we_d = commit_d && pwrite && !addr_err;
    rdata_d  = addr_err ? '0 : mem_rdata;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else if (commit_d) begin
      state_q   <= RESP;
      cnt_q     <= '0;
      pready_q  <= 1'b1;
      pslverr_q <= addr_err;
      if (!pwrite) begin
        prdata_q <= rdata_d;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          // penable without a preceding setup phase is ignored here
          if (psel && !penable && (WAIT_STATES != 0)) begin
            state_q <= WAIT;
            cnt_q   <= CNT_W'(WAIT_STATES);
          end
        end
        WAIT: begin
          if (!psel) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          state_q   <= IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  apb4_sram_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk   (pclk),
    .we    (mem_we_d),
    .strb  (pstrb),
    .index (word_idx[IDX_W-1:0]),
    .wdata (pwdata),
    .rdata (mem_rdata)
  );

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb4_sram.sv
// tb_apb4_sram -- directed bench for apb4_sram using three instances
// (WAIT_STATES = 0, 2, 3) sharing one APB bus with separate psel lines.
module tb_apb4_sram;

  logic        pclk    = 1'b0;
  logic        presetn = 1'b1;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  logic [31:0] prdata0, prdata2, prdata3;
  logic [2:0]  pready_v, pslverr_v;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  // d=0 : WAIT_STATES=0, d=1 : WAIT_STATES=2, d=2 : WAIT_STATES=3
  apb4_sram #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .WAIT_STATES(0)) u_ws0 (
    .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata0), .pready(pready_v[0]), .pslverr(pslverr_v[0]));

  apb4_sram #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .WAIT_STATES(2)) u_ws2 (
    .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata2), .pready(pready_v[1]), .pslverr(pslverr_v[1]));

  apb4_sram #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .WAIT_STATES(3)) u_ws3 (
    .pclk(pclk), .presetn(presetn), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata3), .pready(pready_v[2]), .pslverr(pslverr_v[2]));

  typedef struct {
    int          d;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] erd;
    logic        eerr;
    int          eacc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] rd_of(input int d);
    case (d)
      0:       return prdata0;
      1:       return prdata2;
      default: return prdata3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input logic [31:0] erd, input logic eerr, input int eacc);
    vec_t v;
    v.d = d; v.wr = wr; v.a = a; v.wd = wd; v.st = st;
    v.erd = erd; v.eerr = eerr; v.eacc = eacc;
    tbl.push_back(v);
  endtask

  // Call at posedge+1. Drives setup immediately, then access until pready (bounded),
  // returns at posedge+1 after the completing cycle with the bus released.
  task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic err, output int acc);
    logic done;
    psel = '0; psel[d] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(posedge pclk); #1;
    penable = 1'b1;
    acc = 0; rd = '0; err = 1'b0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge pclk);
      acc++;
      if (pready_v[d] === 1'b1) begin
        rd   = rd_of(d);
        err  = pslverr_v[d];
        done = 1'b1;
      end else begin
        @(posedge pclk); #1;
      end
    end
    if (!done) acc = -1;
    @(posedge pclk); #1;
    psel = '0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          acc;
    int          c0;

    psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;

    // Reset state
    #2 presetn = 1'b0;
    #1;
    check("reset pready",  32'(pready_v),  32'h0);
    check("reset pslverr", 32'(pslverr_v), 32'h0);
    check("reset prdata0", prdata0, 32'h0);
    check("reset prdata2", prdata2, 32'h0);
    check("reset prdata3", prdata3, 32'h0);
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b1;
    @(posedge pclk); #1;

    //   d  wr    addr        wdata         strb   exp rdata     err   acc
    add(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1);
    add(0, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 1);
    add(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0,        1'b0, 1);
    add(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 1);
    add(0, 1'b0, 32'h20, 32'h0,        4'h0, 32'h11BB33DD, 1'b0, 1);
    add(0, 1'b1, 32'h00, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 1);
    add(0, 1'b1, 32'h80, 32'h55555555, 4'hF, 32'h0,        1'b1, 1);
    add(0, 1'b0, 32'h80, 32'h0,        4'h0, 32'h0,        1'b1, 1);
    add(0, 1'b0, 32'h00, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 1);
    add(0, 1'b0, 32'h11, 32'h0,        4'h0, 32'h0,        1'b1, 1);
    add(0, 1'b1, 32'h7C, 32'h12345678, 4'hF, 32'h0,        1'b0, 1);
    add(0, 1'b0, 32'h7C, 32'h0,        4'h0, 32'h12345678, 1'b0, 1);
    add(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 1);
    add(0, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 1);
    add(2, 1'b1, 32'h10, 32'h600DF00D, 4'hF, 32'h0,        1'b0, 4);
    add(2, 1'b0, 32'h10, 32'h0,        4'h0, 32'h600DF00D, 1'b0, 4);
    add(1, 1'b1, 32'h04, 32'h11111111, 4'hF, 32'h0,        1'b0, 3);
    add(1, 1'b0, 32'h04, 32'h0,        4'h0, 32'h11111111, 1'b0, 3);
    add(0, 1'b1, 32'h84, 32'h0BADF00D, 4'hF, 32'h0,        1'b1, 1);

    foreach (tbl[i]) begin
      xfer(tbl[i].d, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].st, rd, err, acc);
      check($sformatf("v%0d pslverr", i), 32'(err), 32'(tbl[i].eerr));
      check($sformatf("v%0d access cycles", i), acc, tbl[i].eacc);
      if (!tbl[i].wr) check($sformatf("v%0d prdata", i), rd, tbl[i].erd);
    end

    // pready/pslverr return low in the cycle after the (error) response
    @(negedge pclk);
    check("post-resp pready",  32'(pready_v[0]),  32'h0);
    check("post-resp pslverr", 32'(pslverr_v[0]), 32'h0);
    @(posedge pclk); #1;

    // penable without setup in IDLE is ignored
    psel = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h0; pstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check($sformatf("no-setup pready c%0d", i), 32'(pready_v[0]), 32'h0);
    end
    @(posedge pclk); #1;
    psel = '0; penable = 1'b0;
    @(posedge pclk); #1;
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, err, acc);
    check("no-setup mem intact", rd, 32'hDEADBEEF);

    // Abort: psel dropped after the first access cycle of a WAIT_STATES=2 write
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h5; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    check("abort pready a1", 32'(pready_v[1]), 32'h0);
    @(posedge pclk); #1;
    psel = '0; penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check($sformatf("abort pready idle%0d", i), 32'(pready_v[1]), 32'h0);
    end
    @(posedge pclk); #1;
    xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, rd, err, acc);
    check("abort read prior value", rd, 32'h11111111);
    check("abort read cycles", acc, 3);

    // Reset mid-WAIT of a write to 0x08
    xfer(1, 1'b1, 32'h08, 32'h0BADCAFE, 4'hF, rd, err, acc);
    xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, rd, err, acc);
    check("pre-reset prdata2", rd, 32'h11111111);
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h99999999; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    #2 presetn = 1'b0;
    #1;
    check("mid-wait reset prdata2",  prdata2, 32'h0);
    check("mid-wait reset prdata0",  prdata0, 32'h0);
    check("mid-wait reset pready",   32'(pready_v),  32'h0);
    check("mid-wait reset pslverr",  32'(pslverr_v), 32'h0);
    psel = '0; penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;

    // Back-to-back write/read after reset: 2 + 2 cycles
    c0 = cyc;
    xfer(0, 1'b1, 32'h30, 32'hA5A5A5A5, 4'hF, rd, err, acc);
    check("b2b write cycles", acc, 1);
    check("b2b write pslverr", 32'(err), 32'h0);
    xfer(0, 1'b0, 32'h30, 32'h0, 4'h0, rd, err, acc);
    check("b2b read cycles", acc, 1);
    check("b2b read prdata", rd, 32'hA5A5A5A5);
    check("b2b total cycles", cyc - c0, 4);

    // The write interrupted by reset must not have landed
    xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, rd, err, acc);
    check("reset-lost write", rd, 32'h0BADCAFE);
    check("reset-lost cycles", acc, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/apb4_sram.md
APB4_SRAM -- requirements
Module: apb4_sram

Interface
REQ-001 Parameter DATA_WIDTH, default 32, bus data width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter ADDR_WIDTH, default 32, paddr width in bits (byte address).
REQ-003 Parameter DEPTH, default 32, number of DATA_WIDTH-bit words.
REQ-004 Parameter WAIT_STATES, default 0, access-phase cycles with pready low before the completing cycle; range 0..15.
REQ-005 pclk  input  1  clock; all state changes on the rising edge.
REQ-006 presetn  input  1  reset; asynchronous, active-low.
REQ-007 psel  input  1  slave select.
REQ-008 penable  input  1  access-phase marker.
REQ-009 pwrite  input  1  1 = write, 0 = read.
REQ-010 paddr  input  ADDR_WIDTH  byte address.
REQ-011 pwdata  input  DATA_WIDTH  write data.
REQ-012 pstrb  input  DATA_WIDTH/8  write byte lanes; ignored on reads.
REQ-013 prdata  output  DATA_WIDTH  read data, registered.
REQ-014 pready  output  1  transfer-complete, registered.
REQ-015 pslverr  output  1  error response, registered; valid only while pready=1.

Function
REQ-016 FSM states SHALL be IDLE, WAIT and RESP.
REQ-017 IDLE with psel=1, penable=0 (setup): go to RESP if WAIT_STATES=0; otherwise go to WAIT and load the counter with WAIT_STATES.
REQ-018 WAIT: the counter decrements each cycle while psel=1; on the edge where counter=1, go to RESP.
REQ-019 The operation SHALL execute on the edge entering RESP. On that edge pready<=1 and pslverr and prdata are set.
REQ-020 Access-phase length SHALL be exactly WAIT_STATES+1 cycles, and pready SHALL be high in the last cycle only.
REQ-021 RESP: on the next edge, go to IDLE, set pready<=0 and pslverr<=0, and hold prdata.
REQ-022 A setup phase in the cycle after RESP SHALL be accepted, allowing back-to-back transfers with no idle cycle.
REQ-023 Word index = paddr >> log2(DATA_WIDTH/8).
REQ-024 Error if the word index >= DEPTH or the low log2(DATA_WIDTH/8) paddr bits are non-zero (misaligned).
REQ-025 Error transfer: no memory update; pslverr=1 with pready=1; for reads, prdata=0.
REQ-026 Good write: update only the byte lanes with pstrb[i]=1; pstrb=0 is a legal no-op with pslverr=0.
REQ-027 Good read: prdata = mem[index] and pslverr=0.
REQ-028 psel=0 in WAIT (abort): go to IDLE with no memory update, and pready stays 0.
REQ-029 penable=1 with the FSM in IDLE (protocol violation): ignore it and stay in IDLE.

Reset
REQ-030 presetn=0 SHALL immediately force state=IDLE, counter=0, prdata=0, pready=0 and pslverr=0, independent of pclk.
REQ-031 Memory contents SHALL NOT be reset; reads before any write return an undefined value.
REQ-032 Reset during WAIT or RESP SHALL abandon the transfer, and any write not yet committed SHALL be lost.
REQ-033 Normal operation SHALL resume on the first setup phase after presetn deasserts.

Structure
REQ-034 Package apb4_sram_pkg SHALL hold the state enum (IDLE, WAIT, RESP) and the default parameter constants.
REQ-035 Sub-module apb4_sram_mem SHALL implement the byte-enabled storage array.
  - Ports: clk, we, strb, index, wdata, rdata.
  - No reset port.
REQ-036 apb4_sram SHALL contain the FSM, wait counter, address decode/error logic and output registers.

Verification
REQ-037 WAIT_STATES=0: write 0xDEADBEEF at 0x10 with pstrb=0xF, then read 0x10.
  - Expected: pready=1 in the first access cycle of each transfer; prdata=0xDEADBEEF; pslverr=0.
REQ-038 WAIT_STATES=3: read 0x10.
  - Expected: pready low for 3 access cycles, high on the 4th, with prdata valid only then.
REQ-039 Byte lanes: write 0x11223344 at 0x20 with pstrb=0xF, then write 0xAABBCCDD with pstrb=0x5, then read 0x20.
  - Expected: prdata=0x11BB33DD.
REQ-040 Errors, DEPTH=32:
  - Write at 0x80 -> pslverr=1.
  - Read at 0x80 -> prdata=0, pslverr=1.
  - Read at 0x11 -> pslverr=1.
  - Read at 0x7C -> pslverr=0.
REQ-041 WAIT_STATES=2: drop psel after the 1st access cycle of a write of 0x5 to 0x04, then read 0x04.
  - Expected: no pready during the aborted write; the read returns the prior value.
REQ-042 Assert presetn=0 mid-WAIT of a write to 0x08.
  - Expected: outputs go to 0 immediately, the FSM returns to IDLE, and a subsequent back-to-back write/read pair completes in 2+2 cycles.
